// File: rtl/ethernet_transmit_pkg.sv
// Shared constants and state encoding for the Ethernet MII transmit path.
package ethernet_transmit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    localparam logic [3:0]  PreambleNibble  = 4'h5;
    localparam logic [3:0]  SfdNibble       = 4'hD;
    localparam int unsigned PreambleNibbles = 16;
    localparam logic [31:0] CrcPoly         = 32'hEDB88320;
    localparam logic [31:0] CrcInit         = 32'hFFFFFFFF;

endpackage

// File: rtl/ethernet_transmit_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, LSB first.
module crc32_nibble
    import ethernet_transmit_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {28'd0, nibble};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/ethernet_transmit.sv
// MII frame transmitter: preamble/SFD, FIFO payload, zero pad, CRC-32 FCS, inter-frame gap.
module ethernet_transmit
    import ethernet_transmit_pkg::*;
#(
    parameter int unsigned MIN_DATA    = 60,
    parameter int unsigned MAX_DATA    = 1514,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic        phy_tx_clk,
    input  logic        reset_n,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        phy_tx_ctrl,
    output logic [3:0]  phy_txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_underrun,
    output logic        tx_reject
);

    localparam logic [10:0] MinLen  = 11'(MIN_DATA);
    localparam logic [10:0] MaxLen  = 11'(MAX_DATA);
    localparam logic [15:0] IfgLast = 16'(IFG_NIBBLES);
    localparam logic [15:0] SfdSlot = 16'(PreambleNibbles - 1);

    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [10:0] len_q;
    logic [10:0] byte_cnt_q;
    logic        hi_q;
    logic [7:0]  byte_q;
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [31:0] fcs_word;
    logic [3:0]  crc_nib_in;
    logic        start_ok;

    assign start_ok = (tx_len != 11'd0) && (tx_len <= MaxLen);
    assign fcs_word = ~crc_q;

    always_comb begin
        crc_nib_in = 4'h0;
        if (state_q == StData) begin
            crc_nib_in = hi_q ? byte_q[7:4] : fifo_dout[3:0];
        end
    end

    crc32_nibble u_crc (
        .crc     (crc_q),
        .nibble  (crc_nib_in),
        .crc_next(crc_next)
    );

    // Outputs are registered one cycle ahead of the wire; the pop is issued in the
    // high-nibble phase so the FWFT FIFO presents the next byte by the next low slot.
    always_ff @(posedge phy_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            hi_q        <= 1'b0;
            byte_q      <= '0;
            crc_q       <= CrcInit;
            fifo_rd_en  <= 1'b0;
            phy_tx_ctrl <= 1'b0;
            phy_txd     <= 4'h0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_reject   <= 1'b0;
        end else begin
            fifo_rd_en  <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_reject   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    phy_tx_ctrl <= 1'b0;
                    phy_txd     <= 4'h0;
                    tx_busy     <= 1'b0;
                    if (tx_start) begin
                        if (start_ok) begin
                            state_q     <= StPreamble;
                            len_q       <= tx_len;
                            cnt_q       <= 16'd1;
                            crc_q       <= CrcInit;
                            phy_tx_ctrl <= 1'b1;
                            phy_txd     <= PreambleNibble;
                            tx_busy     <= 1'b1;
                        end else begin
                            tx_reject <= 1'b1;
                        end
                    end
                end
                StPreamble: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == SfdSlot) begin
                        phy_txd    <= SfdNibble;
                        state_q    <= StData;
                        hi_q       <= 1'b0;
                        byte_cnt_q <= '0;
                    end else begin
                        phy_txd <= PreambleNibble;
                    end
                end
                StData: begin
                    if (!hi_q) begin
                        if (fifo_empty) begin
                            phy_tx_ctrl <= 1'b0;
                            phy_txd     <= 4'h0;
                            tx_underrun <= 1'b1;
                            cnt_q       <= 16'd1;
                            state_q     <= StIfg;
                        end else begin
                            byte_q     <= fifo_dout;
                            phy_txd    <= fifo_dout[3:0];
                            crc_q      <= crc_next;
                            fifo_rd_en <= 1'b1;
                            hi_q       <= 1'b1;
                        end
                    end else begin
                        phy_txd    <= byte_q[7:4];
                        crc_q      <= crc_next;
                        hi_q       <= 1'b0;
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        if (byte_cnt_q == len_q - 11'd1) begin
                            cnt_q   <= '0;
                            state_q <= (len_q < MinLen) ? StPad : StFcs;
                        end
                    end
                end
                StPad: begin
                    phy_txd <= 4'h0;
                    crc_q   <= crc_next;
                    hi_q    <= ~hi_q;
                    if (hi_q) begin
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        if (byte_cnt_q == MinLen - 11'd1) begin
                            cnt_q   <= '0;
                            state_q <= StFcs;
                        end
                    end
                end
                StFcs: begin
                    if (cnt_q[3]) begin
                        phy_tx_ctrl <= 1'b0;
                        phy_txd     <= 4'h0;
                        tx_done     <= 1'b1;
                        cnt_q       <= 16'd1;
                        state_q     <= StIfg;
                    end else begin
                        phy_txd <= fcs_word[{cnt_q[2:0], 2'b00} +: 4];
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
                StIfg: begin
                    phy_tx_ctrl <= 1'b0;
                    phy_txd     <= 4'h0;
                    if (cnt_q >= IfgLast) begin
                        state_q <= StIdle;
                        tx_busy <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_transmit.sv
// Directed bench for ethernet_transmit: frame shape, padding, FCS residue, underrun, reject, reset.
module tb_ethernet_transmit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_start = 1'b0;
    logic [10:0] tx_len = '0;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en, phy_tx_ctrl, tx_busy, tx_done, tx_underrun, tx_reject;
    logic [3:0]  phy_txd;

    always #20 clk = ~clk;

    ethernet_transmit dut (
        .phy_tx_clk (clk),
        .reset_n    (rst_n),
        .tx_start   (tx_start),
        .tx_len     (tx_len),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .phy_tx_ctrl(phy_tx_ctrl),
        .phy_txd    (phy_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_underrun(tx_underrun),
        .tx_reject  (tx_reject)
    );

    // FWFT FIFO model
    logic [7:0] fifo_mem [0:1023];
    int rd_ptr = 0;
    int fifo_level = 0;
    assign fifo_dout  = fifo_mem[rd_ptr[9:0]];
    assign fifo_empty = (rd_ptr >= fifo_level);
    always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

    // Wire monitor
    logic [3:0] cap [0:4095];
    int cap_n = 0, pops = 0, dones = 0, underruns = 0, rejects = 0, viol = 0;
    int low_run = 1000, last_gap = 0;
    always @(negedge clk) begin
        if (phy_tx_ctrl) begin
            cap[cap_n[11:0]] <= phy_txd;
            cap_n <= cap_n + 1;
            if (low_run != 0) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
            if (phy_txd !== 4'h0) viol <= viol + 1;
        end
        if (fifo_rd_en) pops <= pops + 1;
        if (tx_done) dones <= dones + 1;
        if (tx_underrun) underruns <= underruns + 1;
        if (tx_reject) rejects <= rejects + 1;
    end

    int n_pass = 0, n_chk = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] nib(input int i);
        return cap[i[11:0]];
    endfunction

    function automatic logic [31:0] crc_nib(input logic [31:0] c_in, input logic [3:0] n);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int b = 0; b < 4; b++) begin
            fb = c[0] ^ n[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return r;
    endfunction

    task automatic fill(input int n, input int lvl);
        for (int k = 0; k < n; k++) begin
            int a;
            a = rd_ptr + k;
            fifo_mem[a[9:0]] = 8'(k);
        end
        fifo_level = rd_ptr + lvl;
    endtask

    task automatic start(input logic [10:0] len);
        tx_len   = len;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (tx_busy === 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, tx_busy, 0);
    endtask

    task automatic check_frame(input int s, input int len, input string tag);
        int m, total;
        logic pre_ok, dat_ok;
        logic [31:0] c;
        logic [7:0] b;
        logic [3:0] e;
        m      = (len < 60) ? 60 : len;
        total  = 16 + 2 * m + 8;
        pre_ok = 1'b1;
        dat_ok = 1'b1;
        c      = 32'hFFFFFFFF;
        check({tag, "_ctrl_cycles"}, cap_n - s, total);
        for (int i = 0; i < 15; i++) if (nib(s + i) !== 4'h5) pre_ok = 1'b0;
        if (nib(s + 15) !== 4'hD) pre_ok = 1'b0;
        check({tag, "_preamble"}, pre_ok, 1);
        for (int j = 0; j < 2 * m; j++) begin
            b = (j / 2 < len) ? 8'(j / 2) : 8'h00;
            e = (j % 2 == 1) ? b[7:4] : b[3:0];
            if (nib(s + 16 + j) !== e) dat_ok = 1'b0;
        end
        check({tag, "_data_pad"}, dat_ok, 1);
        for (int j = 0; j < 2 * m + 8; j++) c = crc_nib(c, nib(s + 16 + j));
        check({tag, "_fcs_residue"}, bitrev(c), 32'hC704DD7B);
    endtask

    initial begin
        int s, s2, p0, d0, u0, r0, t, n;
        #5 rst_n = 1'b0;
        #1 check("reset_outputs",
                 {phy_tx_ctrl, phy_txd, fifo_rd_en, tx_busy, tx_done, tx_underrun, tx_reject}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 64-byte frame, no padding
        fill(64, 64);
        s = cap_n; p0 = pops; d0 = dones;
        start(11'd64);
        check("A_ctrl_next_cycle", phy_tx_ctrl, 1);
        check("A_busy", tx_busy, 1);
        wait_idle("A");
        check_frame(s, 64, "A");
        check("A_pops", pops - p0, 64);
        check("A_done", dones - d0, 1);

        // 14-byte frame, 46 pad bytes
        fill(14, 14);
        s = cap_n; p0 = pops;
        start(11'd14);
        wait_idle("B");
        check_frame(s, 14, "B");
        check("B_pops", pops - p0, 14);

        // exactly MIN_DATA, no padding
        fill(60, 60);
        s = cap_n; p0 = pops;
        start(11'd60);
        wait_idle("B60");
        check_frame(s, 60, "B60");
        check("B60_pops", pops - p0, 60);

        // FIFO runs dry at byte 20
        fill(64, 20);
        s = cap_n; p0 = pops; d0 = dones; u0 = underruns;
        start(11'd64);
        t = 0;
        while (tx_underrun !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("C_ctrl_low_at_abort", phy_tx_ctrl, 0);
        n = 0;
        while (tx_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("C_ifg_cycles", n, 24);
        check("C_ctrl_cycles", cap_n - s, 56);
        check("C_pops", pops - p0, 20);
        check("C_underrun_pulse", underruns - u0, 1);
        check("C_no_done", dones - d0, 0);

        // request during IFG is ignored, next one after busy falls is taken
        fill(20, 20);
        s = cap_n; d0 = dones; r0 = rejects;
        start(11'd20);
        t = 0;
        while (phy_tx_ctrl === 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check("D_in_ifg", tx_busy, 1);
        start(11'd20);
        check("D_no_reject", tx_reject, 0);
        check("D_ignored_ctrl", phy_tx_ctrl, 0);
        wait_idle("D1");
        check_frame(s, 20, "D1");
        fill(20, 20);
        s2 = cap_n;
        start(11'd20);
        check("D2_accepted", phy_tx_ctrl, 1);
        wait_idle("D2");
        check_frame(s2, 20, "D2");
        check("D_gap_ge24", (last_gap >= 24), 1);
        check("D_rejects", rejects - r0, 0);
        check("D_dones", dones - d0, 2);

        // illegal lengths
        s = cap_n; p0 = pops; r0 = rejects;
        start(11'd0);
        check("E_reject_len0", tx_reject, 1);
        check("E_ctrl_len0", phy_tx_ctrl, 0);
        @(negedge clk);
        check("E_reject_one_cycle", tx_reject, 0);
        start(11'd1515);
        check("E_reject_len1515", tx_reject, 1);
        @(negedge clk);
        check("E_busy", tx_busy, 0);
        check("E_rejects", rejects - r0, 2);
        check("E_no_pops", pops - p0, 0);
        check("E_no_ctrl", cap_n - s, 0);

        // reset in the middle of DATA
        fill(64, 64);
        p0 = pops; d0 = dones; u0 = underruns;
        start(11'd64);
        t = 0;
        while (pops - p0 < 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #5 rst_n = 1'b0;
        #1 check("F_reset_outputs",
                 {phy_tx_ctrl, phy_txd, fifo_rd_en, tx_busy, tx_done, tx_underrun, tx_reject}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(64, 64);
        s2 = cap_n;
        start(11'd64);
        check("F_first_cycle_accept", phy_tx_ctrl, 1);
        wait_idle("F");
        check_frame(s2, 64, "F");
        check("F_one_done", dones - d0, 1);
        check("F_no_underrun", underruns - u0, 0);

        check("txd_zero_when_ctrl_low", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
